// File: rtl/tas_avg_wr_sched.sv
// Drains temperature bytes from the clk_2-side FIFO and averages each group of
// SAMPLES bytes. Each average is written to RAM with a one-cycle active-low strobe
// at a down-counting, wrapping address.
module tas_avg_wr_sched #(
  parameter int unsigned SAMPLES   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned ADDR_INIT = (1 << ADDR_W) - 1
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd_fifo,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              wr_done
);

  localparam int unsigned       CNT_W    = $clog2(SAMPLES);
  localparam int unsigned       ACC_W    = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(ADDR_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SETUP,
    S_STROBE,
    S_ADV
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_ram_data;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ACC_W-1:0]  w_sum;
  logic              w_last;

  assign w_sum  = r_acc + {{CNT_W{1'b0}}, fifo_data};
  assign w_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!fifo_empty) w_next = S_RD;
      S_RD:     w_next = S_CAP;
      S_CAP: begin
        if (w_last)           w_next = S_SETUP;
        else if (!fifo_empty) w_next = S_RD;
        else                  w_next = S_IDLE;
      end
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: w_next = S_ADV;
      S_ADV:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register alone
  always_comb begin
    rd_fifo  = (r_state == S_RD);
    ram_wr_n = (r_state != S_STROBE);
    wr_done  = (r_state == S_ADV);
    ram_data = r_ram_data;
    ram_addr = r_ram_addr;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ram_data <= '0;
      r_ram_addr <= ADDR_RST;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CAP: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
          // top DATA_W bits of the sum are the truncated average
          if (w_last) r_ram_data <= w_sum[ACC_W-1 -: DATA_W];
        end
        S_ADV: begin
          r_acc      <= '0;
          r_cnt      <= '0;
          r_ram_addr <= (r_ram_addr == '0) ? ADDR_RST : r_ram_addr - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tas_avg_wr_sched.sv
// Bench for tas_avg_wr_sched: a queue-based FIFO source, a group-average/address
// reference model, table vectors, random starved streaming, wrap and reset aborts.
module tb_tas_avg_wr_sched;

  localparam logic [10:0] A_INIT = 11'h7FF;

  logic        clk;
  logic        reset;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        rd_fifo;
  logic        ram_wr_n;
  logic [7:0]  ram_data;
  logic [10:0] ram_addr;
  logic        wr_done;

  tas_avg_wr_sched #(.SAMPLES(4), .DATA_W(8), .ADDR_W(11), .ADDR_INIT(2047)) dut (
    .clk_2     (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .rd_fifo   (rd_fifo),
    .ram_wr_n  (ram_wr_n),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .wr_done   (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    int unsigned t;
  } src_t;

  typedef struct {
    logic [31:0] bytes;
    logic [7:0]  avg;
  } vec_t;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  src_t        src[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  grp[$];
  logic [7:0]  exp_q[$];
  logic [10:0] addr_exp = A_INIT;
  int unsigned cyc = 0;
  int unsigned last_rd = 0;
  int unsigned n_pops = 0;
  int unsigned n_done = 0;
  int unsigned dut_done = 0;
  logic [7:0]  last_data = '0;
  logic [10:0] last_addr = '0;
  logic        prev_reset = 1'b0;
  logic        prev_strobe = 1'b0;
  logic        prev_adv = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [10:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // FIFO source and reference model, evaluated mid-cycle
  always @(negedge clk) begin
    logic [7:0]  b;
    int unsigned s;
    src_t        e;
    logic        exp_done;
    cyc++;

    if (prev_reset)
      chk("reset_vals", {rd_fifo, ram_wr_n, wr_done, ram_addr, ram_data},
          {1'b0, 1'b1, 1'b0, A_INIT, 8'h00});

    while (src.size() > 0 && src[0].t <= cyc) begin
      e = src.pop_front();
      fifo_q.push_back(e.d);
    end

    if (rd_fifo === 1'b1) begin
      chk("rd_legal", {31'b0, (fifo_q.size() != 0 && exp_q.size() == 0)}, 1);
      if (fifo_q.size() != 0) begin
        b = fifo_q.pop_front();
        fifo_data = b;
        grp.push_back(b);
        n_pops++;
        last_rd = cyc;
        if (grp.size() == 4) begin
          s = 0;
          foreach (grp[k]) s += grp[k];
          exp_q.push_back(8'(s / 4));
          grp.delete();
        end
      end
    end

    if (ram_wr_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("extra_strobe", 1, 0);
      end else begin
        b = exp_q.pop_front();
        chk("wr_data", ram_data, b);
        chk("wr_addr", ram_addr, addr_exp);
        chk("wr_timing", cyc - last_rd, 3);
        chk("setup_stable", {ram_data, ram_addr}, {prev_data, prev_addr});
      end
      last_data = ram_data;
      last_addr = ram_addr;
    end

    exp_done = prev_strobe && !prev_reset;
    if (wr_done === 1'b1) dut_done++;
    if (wr_done !== 1'b0 || exp_done)
      chk("wr_done", {wr_done, ram_data, ram_addr}, {exp_done, last_data, last_addr});
    if (prev_adv) chk("addr_adv", ram_addr, addr_exp);
    if (exp_done) begin
      n_done++;
      addr_exp = (addr_exp == 0) ? A_INIT : addr_exp - 11'd1;
    end

    if (reset) begin
      grp.delete();
      exp_q.delete();
      fifo_q.delete();
      src.delete();
      addr_exp = A_INIT;
    end
    fifo_empty = (fifo_q.size() == 0);

    prev_reset  = reset;
    prev_strobe = (ram_wr_n === 1'b0);
    prev_adv    = exp_done;
    prev_data   = ram_data;
    prev_addr   = ram_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input int unsigned t);
    src.push_back('{d: d, t: t});
  endtask

  task automatic wait_writes(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_writes_timeout", {31'b0, n_done >= target}, 1);
  endtask

  task automatic wait_pops(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (n_pops < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_pops_timeout", {31'b0, n_pops >= target}, 1);
  endtask

  vec_t tbl[7];

  initial begin
    int unsigned t;
    int unsigned nd;
    int unsigned k;
    reset      = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = '0;

    tbl[0] = '{bytes: 32'h40302010, avg: 8'h28};
    tbl[1] = '{bytes: 32'h02010101, avg: 8'h01};
    tbl[2] = '{bytes: 32'hFFFFFFFF, avg: 8'hFF};
    tbl[3] = '{bytes: 32'h00000000, avg: 8'h00};
    tbl[4] = '{bytes: 32'h00000003, avg: 8'h00};
    tbl[5] = '{bytes: 32'h7F808080, avg: 8'h7F};
    tbl[6] = '{bytes: 32'hFFFFFFFE, avg: 8'hFE};

    repeat (3) tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      nd = n_done;
      for (int j = 0; j < 4; j++) push(tbl[i].bytes[8*j +: 8], cyc);
      wait_writes(nd + 1, 100);
      chk("tbl_avg", last_data, tbl[i].avg);
      chk("tbl_addr", last_addr, 32'h7FF - i);
      repeat (2) tick();
    end

    do_reset();
    tick();

    // starved FIFO: random bytes with 0..10 cycle gaps
    t = cyc;
    nd = n_done;
    for (int i = 0; i < 160; i++) begin
      t += $urandom_range(0, 10);
      push(8'($urandom), t);
    end
    wait_writes(nd + 40, 5000);

    // wrap: 2049 back-to-back groups from reset
    do_reset();
    tick();
    nd = n_done;
    for (int i = 0; i < 2049 * 4; i++) push(8'($urandom), cyc);
    wait_writes(nd + 2049, 30000);
    chk("wrap_addr", last_addr, A_INIT);
    repeat (3) tick();

    // reset after 2 bytes of a group
    do_reset();
    tick();
    k = n_pops;
    for (int j = 0; j < 4; j++) push(8'hF0, cyc);
    wait_pops(k + 2, 100);
    do_reset();
    tick();
    nd = n_done;
    for (int j = 0; j < 4; j++) push(8'h08, cyc);
    wait_writes(nd + 1, 100);
    chk("abort2_data", last_data, 8'h08);
    chk("abort2_addr", last_addr, A_INIT);
    repeat (20) tick();
    chk("abort2_single", n_done, nd + 1);

    // reset during STROBE
    for (int j = 0; j < 4; j++) push(8'h55, cyc);
    k = 0;
    while (ram_wr_n !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    chk("strobe_seen", {31'b0, ram_wr_n === 1'b0}, 1);
    nd = dut_done;
    do_reset();
    repeat (10) tick();
    chk("abort_strobe_no_done", dut_done, nd);
    nd = n_done;
    for (int j = 0; j < 4; j++) push(8'h08, cyc);
    wait_writes(nd + 1, 100);
    chk("abortS_data", last_data, 8'h08);
    chk("abortS_addr", last_addr, A_INIT);
    repeat (20) tick();
    chk("abortS_single", n_done, nd + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
